// File: rtl/memory_bus_pkg.sv
// rtl/memory_bus_pkg.sv - slave bus command/result types shared with SlaveBusMux
package MemoryBus;

  typedef struct packed {
    logic [31:0] write_data;
    logic        mem_read;
  } Cmd;

  typedef struct packed {
    logic [31:0] read_data;
  } Result;

endpackage

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, STATUS bit positions and FSM states for the UART transmitter
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVR   = 3;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - power-of-two TX FIFO; occupancy tracked by count so full/empty never alias
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - 8N1 UART transmitter slave; UART_TX_FIFO_EN selects FIFO vs single holding register
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int DIVISOR    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_enable,
  input  logic [1:0]       bus_address,
  input  MemoryBus::Cmd    membuscmd,
  output MemoryBus::Result membusres,
  output logic             tx
);

  localparam logic [15:0] DIV_RESET = clamp_div(16'(DIVISOR));

  tx_state_t   state;
  logic [15:0] div_reg;
  logic [15:0] cur_div;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shifter;
  logic        ovr;

  logic        push;
  logic        pop;
  logic        q_full;
  logic        q_empty;
  logic [7:0]  q_head;
  logic        bit_end;
  logic [3:0]  status;
  logic        unused_bits;

  assign push    = write_enable && (bus_address == REG_DATA);
  assign bit_end = (clk_cnt == cur_div - 16'd1);

  always_comb begin
    pop = 1'b0;
    if (!q_empty && (state == S_IDLE || (state == S_STOP && bit_end))) pop = 1'b1;
  end

`ifdef UART_TX_FIFO_EN
  logic [$clog2(FIFO_DEPTH):0] q_count;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (membuscmd.write_data[7:0]),
    .pop       (pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign unused_bits = ^{membuscmd.write_data[31:16], q_count};
`else
  logic       hold_valid;
  logic [7:0] hold_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= 8'h00;
    end else if (push && (!hold_valid || pop)) begin
      hold_valid <= 1'b1;
      hold_data  <= membuscmd.write_data[7:0];
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign q_full      = hold_valid;
  assign q_empty     = !hold_valid;
  assign q_head      = hold_data;
  assign unused_bits = ^membuscmd.write_data[31:16];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= DIV_RESET;
      ovr     <= 1'b0;
    end else if (write_enable) begin
      case (bus_address)
        REG_DATA:   if (q_full && !pop) ovr <= 1'b1;
        REG_STATUS: if (membuscmd.write_data[STAT_OVR]) ovr <= 1'b0;
        REG_DIV:    div_reg <= clamp_div(membuscmd.write_data[15:0]);
        default:    ;
      endcase
    end
  end

  // Frame start latches the byte and the divisor, so DIV writes only affect the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shifter <= '0;
      cur_div <= DIV_RESET;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state   <= S_START;
            tx      <= 1'b0;
            shifter <= q_head;
            cur_div <= div_reg;
            clk_cnt <= '0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            clk_cnt <= '0;
            bit_cnt <= '0;
            tx      <= shifter[0];
            shifter <= shifter >> 1;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shifter[0];
              shifter <= shifter >> 1;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (pop) begin
              state   <= S_START;
              tx      <= 1'b0;
              shifter <= q_head;
              cur_div <= div_reg;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    status             = '0;
    status[STAT_BUSY]  = (state != S_IDLE);
    status[STAT_FULL]  = q_full;
    status[STAT_EMPTY] = q_empty;
    status[STAT_OVR]   = ovr;
  end

  // While rst is high the registers still hold old values, so reads show reset values directly.
  always_comb begin
    membusres = '0;
    if (membuscmd.mem_read) begin
      case (bus_address)
        REG_STATUS: membusres.read_data = rst ? 32'(4'b0100) : {28'b0, status};
        REG_DIV:    membusres.read_data = rst ? {16'b0, DIV_RESET} : {16'b0, div_reg};
        default:    membusres.read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - randomized and directed checks against a frame-timeline reference model
module tb_uart_tx_periph;

  localparam int DIVISOR = 434;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif

  logic             clk;
  logic             rst;
  logic             write_enable;
  logic [1:0]       bus_address;
  MemoryBus::Cmd    cmd;
  MemoryBus::Result res;
  logic             tx;

  uart_tx_periph #(.DIVISOR(DIVISOR), .FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .bus_address  (bus_address),
    .membuscmd    (cmd),
    .membusres    (res),
    .tx           (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending byte queue plus the timeline of the frame on the wire.
  logic [7:0] q[$];
  int         edge_n = 0;
  bit         fr_active = 0;
  int         fr_start = 0;
  int         fr_div = 1;
  logic [7:0] fr_byte = 0;
  bit         m_ovr = 0;
  int         m_div = DIVISOR;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_edge(input logic we, input logic [1:0] a, input logic [31:0] d, input logic r);
    bit popped;
    edge_n++;
    if (r) begin
      q.delete();
      fr_active = 0;
      m_ovr = 0;
      m_div = DIVISOR;
      return;
    end
    popped = 0;
    if (!fr_active || edge_n == fr_start + 10 * fr_div) begin
      if (q.size() > 0) begin
        fr_byte   = q.pop_front();
        fr_start  = edge_n;
        fr_div    = m_div;
        fr_active = 1;
        popped    = 1;
      end else begin
        fr_active = 0;
      end
    end
    if (we) begin
      case (a)
        2'd0: if (q.size() < CAP) q.push_back(d[7:0]); else m_ovr = 1;
        2'd1: if (d[3]) m_ovr = 0;
        2'd2: m_div = (d[15:0] < 2) ? 2 : int'(d[15:0]);
        default: ;
      endcase
    end
  endtask

  function automatic logic exp_tx();
    int idx;
    if (!fr_active) return 1'b1;
    idx = (edge_n - fr_start) / fr_div;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return fr_byte[idx-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    case (a)
      2'd1: return {28'b0, m_ovr, q.size() == 0, q.size() == CAP, fr_active};
      2'd2: return 32'(m_div);
      default: return 32'h0;
    endcase
  endfunction

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    bus_address  = a;
    cmd.mem_read = 1'b1;
    #1;
    v = res.read_data;
    cmd.mem_read = 1'b0;
  endtask

  task automatic step(input logic we, input logic [1:0] a, input logic [31:0] d, input logic r);
    logic [1:0]  ra;
    logic [31:0] v;
    rst            = r;
    write_enable   = we;
    bus_address    = a;
    cmd.write_data = d;
    cmd.mem_read   = 1'b0;
    @(posedge clk);
    model_edge(we, a, d, r);
    #1;
    write_enable = 1'b0;
    rst          = 1'b0;
    check("tx", 32'(tx), 32'(exp_tx()));
    ra = 2'($urandom_range(0, 3));
    read_reg(ra, v);
    check("read", v, exp_read(ra));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'h0, 1'b0);
  endtask

  logic [31:0] rv;
  int          r;

  initial begin
    rst = 1'b1;
    write_enable = 1'b0;
    bus_address = 2'd0;
    cmd = '0;

    step(1'b0, 2'd0, 32'h0, 1'b1);
    step(1'b0, 2'd0, 32'h0, 1'b1);
    read_reg(2'd1, rv); check("rst_status", rv, 32'h4);
    read_reg(2'd2, rv); check("rst_div", rv, 32'd434);
    check("rst_tx", 32'(tx), 32'h1);

    // 0x55 frame at DIV=4
    step(1'b1, 2'd2, 32'd4, 1'b0);
    step(1'b1, 2'd0, 32'hABCD_0055, 1'b0);
    idle(1);
    check("req33_start_low", 32'(tx), 32'h0);
    idle(40);
    read_reg(2'd1, rv); check("req33_idle_status", rv, 32'h4);

    // back-to-back frames
    step(1'b1, 2'd0, 32'h00, 1'b0);
    step(1'b1, 2'd0, 32'hFF, 1'b0);
    idle(85);

    // DIV clamp and mid-frame change
    step(1'b1, 2'd2, 32'd1, 1'b0);
    read_reg(2'd2, rv); check("div_clamp", rv, 32'd2);
    step(1'b1, 2'd2, 32'd4, 1'b0);
    step(1'b1, 2'd0, 32'hA5, 1'b0);
    step(1'b1, 2'd0, 32'h3C, 1'b0);
    idle(7);
    step(1'b1, 2'd2, 32'd10, 1'b0);
    idle(150);

    // overflow at DIV=1000
    step(1'b1, 2'd2, 32'd1000, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 2'd0, $urandom(), 1'b0);
    read_reg(2'd1, rv); check("ovr_status", rv, 32'h0B);
    step(1'b1, 2'd1, 32'h8, 1'b0);
    read_reg(2'd1, rv); check("ovr_cleared", rv, 32'h03);
    rst = 1'b1;
    read_reg(2'd1, rv); check("rst_read_status", rv, 32'h4);
    read_reg(2'd2, rv); check("rst_read_div", rv, 32'd434);
    step(1'b1, 2'd2, 32'd77, 1'b1);
    read_reg(2'd2, rv); check("rst_write_ignored", rv, 32'd434);

    // reset during data bit 3 with bytes queued
    step(1'b1, 2'd2, 32'd4, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 32'($urandom_range(0, 255)), 1'b0);
    idle(15);
    step(1'b0, 2'd0, 32'h0, 1'b1);
    check("abort_tx", 32'(tx), 32'h1);
    read_reg(2'd1, rv); check("abort_status", rv, 32'h4);
    step(1'b1, 2'd2, 32'd3, 1'b0);
    idle(60);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      step(1'b1, 2'd0, $urandom(), 1'b0);
      else if (r < 23) step(1'b1, 2'd2, {16'($urandom()), 16'($urandom_range(0, 6))}, 1'b0);
      else if (r < 26) step(1'b1, 2'd1, $urandom(), 1'b0);
      else if (r < 28) step(1'b1, 2'd3, $urandom(), 1'b0);
      else if (r == 99 && $urandom_range(0, 3) == 0) step(1'b0, 2'd0, 32'h0, 1'b1);
      else             idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
